// File: rtl/alu_issue_capture_pkg.sv
// Shared types and defaults for the ALU issue/capture front end.
package alu_issue_capture_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_CTRL_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_issue_capture_if.sv
// Request, ALU-side and response signals of the capture block; slave is the capture block itself.
interface alu_issue_capture_if
    import alu_issue_capture_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CTRL_W = DEF_CTRL_W
);
    logic              req_valid;
    logic              req_ready;
    logic [WIDTH-1:0]  req_a;
    logic [WIDTH-1:0]  req_b;
    logic [CTRL_W-1:0] req_ctrl;

    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [WIDTH-1:0]  alu_c;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_c;
    logic              rsp_unstable;

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, alu_c, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_c, rsp_unstable
    );

    modport master (
        output req_valid, req_a, req_b, req_ctrl, alu_c, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_c, rsp_unstable
    );

endinterface

// File: rtl/alu_issue_capture_settle_timer.sv
// Loadable down-counter that times the operand settle window; done while the count sits at zero.
module alu_issue_capture_settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Load wins over decrement so a retry can restart the window from CHECK.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_issue_capture.sv
// Registers operands into the combinational ALU, waits out the settle window, double-samples C
// and returns it on a valid/ready response, retrying a bounded number of times if C is still moving.
module alu_issue_capture
    import alu_issue_capture_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int CTRL_W        = DEF_CTRL_W,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_RETRY     = 2
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    alu_issue_capture_if.slave      bus,
    output logic [7:0]              op_count
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e            state_q;
    state_e            state_d;
    logic [WIDTH-1:0]  alu_a_q;
    logic [WIDTH-1:0]  alu_b_q;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic [WIDTH-1:0]  sample1_q;
    logic [WIDTH-1:0]  rsp_c_q;
    logic              rsp_valid_q;
    logic              rsp_unstable_q;
    logic [7:0]        op_count_q;
    logic [RW-1:0]     retry_q;

    logic accept;
    logic match;
    logic can_retry;
    logic tmr_load;
    logic tmr_dec;
    logic tmr_done;

    alu_issue_capture_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .load_i (tmr_load),
        .dec_i  (tmr_dec),
        .done_o (tmr_done)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q        <= IDLE;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_ctrl_q     <= '0;
            sample1_q      <= '0;
            rsp_c_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_unstable_q <= 1'b0;
            op_count_q     <= 8'd0;
            retry_q        <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a_q    <= bus.req_a;
                alu_b_q    <= bus.req_b;
                alu_ctrl_q <= bus.req_ctrl;
                retry_q    <= '0;
            end
            if ((state_q == SETTLE) && tmr_done) begin
                sample1_q <= bus.alu_c;
            end
            // A mismatch with retries exhausted still answers, but flags the result as unreliable.
            if (state_q == CHECK) begin
                if (match || !can_retry) begin
                    rsp_c_q        <= bus.alu_c;
                    rsp_unstable_q <= !match;
                    rsp_valid_q    <= 1'b1;
                end else begin
                    retry_q <= retry_q + RW'(1);
                end
            end
            if ((state_q == RESP) && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
                op_count_q  <= op_count_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)         state_d = SETTLE;
            SETTLE:  if (tmr_done)       state_d = CHECK;
            CHECK:   if (match)          state_d = RESP;
                     else if (can_retry) state_d = SETTLE;
                     else                state_d = RESP;
            RESP:    if (bus.rsp_ready)  state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE) && !wb_rst_i;
        accept        = bus.req_ready && bus.req_valid;
        match         = (bus.alu_c == sample1_q);
        can_retry     = (retry_q < RW'(MAX_RETRY));
        tmr_load      = accept || ((state_q == CHECK) && !match && can_retry);
        tmr_dec       = (state_q == SETTLE);
    end

    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
    assign bus.alu_ctrl     = alu_ctrl_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_c        = rsp_c_q;
    assign bus.rsp_unstable = rsp_unstable_q;
    assign op_count         = op_count_q;

endmodule

// File: tb/tb_alu_issue_capture.sv
// Bench for alu_issue_capture: adder ALU stub with an optional C-toggling glitch, scoreboarded responses.
module tb_alu_issue_capture;
    import alu_issue_capture_pkg::*;

    localparam int WIDTH  = 4;
    localparam int CTRL_W = 2;

    typedef struct {
        logic [WIDTH-1:0] c;
        logic             unstable;
        int               latency;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic [CTRL_W-1:0] ctrl;
        logic [WIDTH-1:0]  c;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       opCount;
    logic [WIDTH-1:0] cMask = '0;
    int               toggleLeft = 0;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle = 0;
    int   acceptCycle = 0;
    int   lastHsCycle = -100;
    int   acceptCount = 0;
    bit   checkGap = 1'b0;
    logic rspValidPrev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    alu_issue_capture_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) bus ();

    alu_issue_capture #(
        .WIDTH         (WIDTH),
        .CTRL_W        (CTRL_W),
        .SETTLE_CYCLES (4),
        .MAX_RETRY     (2)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus.slave),
        .op_count (opCount)
    );

    // ALU stub: sum with interconnect delay, optionally corrupted by a toggling mask.
    assign #1 bus.alu_c = (bus.alu_a + bus.alu_b) ^ cMask;

    always @(negedge clk) begin
        if (toggleLeft > 0) begin
            cMask = ~cMask;
            toggleLeft--;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Monitor: checks each response against the scoreboard when it appears and again at handshake.
    always @(negedge clk) begin
        if (rst) begin
            rspValidPrev = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                acceptCycle = cycle + 1;
                acceptCount++;
                if (checkGap) checkOutput("acceptGap", acceptCycle - lastHsCycle, 1);
            end
            if (bus.rsp_valid && !rspValidPrev) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedRsp", 1, 0);
                end else begin
                    checkOutput("rspC", int'(bus.rsp_c), int'(expQ[0].c));
                    checkOutput("rspUnstable", int'(bus.rsp_unstable), int'(expQ[0].unstable));
                    checkOutput("rspLatency", cycle - acceptCycle, expQ[0].latency);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready && (expQ.size() > 0)) begin
                checkOutput("rspHeldC", int'(bus.rsp_c), int'(expQ[0].c));
                void'(expQ.pop_front());
                lastHsCycle = cycle + 1;
            end
            rspValidPrev = bus.rsp_valid;
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [CTRL_W-1:0] ctrl, input logic [WIDTH-1:0] c,
                                 input logic unst, input int lat);
        int waitCycles = 0;
        @(posedge clk);
        #2;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_ctrl  = ctrl;
        expQ.push_back('{c: c, unstable: unst, latency: lat});
        @(negedge clk);
        while (!bus.req_ready && waitCycles < 60) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!bus.req_ready) checkOutput("acceptTimeout", 0, 1);
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() > 0) begin
            checkOutput("drainTimeout", expQ.size(), 0);
            expQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        vec_t table1[6];
        int   acc0;
        int   n;
        table1[0] = '{a: 4'd9,  b: 4'd9, ctrl: 2'd0, c: 4'd2};
        table1[1] = '{a: 4'd7,  b: 4'd7, ctrl: 2'd1, c: 4'd14};
        table1[2] = '{a: 4'd15, b: 4'd1, ctrl: 2'd2, c: 4'd0};
        table1[3] = '{a: 4'd12, b: 4'd5, ctrl: 2'd3, c: 4'd1};
        table1[4] = '{a: 4'd0,  b: 4'd0, ctrl: 2'd0, c: 4'd0};
        table1[5] = '{a: 4'd6,  b: 4'd8, ctrl: 2'd1, c: 4'd14};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_ctrl  = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("readyInReset", int'(bus.req_ready), 0);
        checkOutput("rspValidReset", int'(bus.rsp_valid), 0);
        checkOutput("opCountReset", int'(opCount), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterReset", int'(bus.req_ready), 1);

        // Single transaction, then op_count.
        applyStimulus(4'd2, 4'd3, 2'd0, 4'd5, 1'b0, 5);
        waitDrain();
        checkOutput("opCountOne", int'(opCount), 1);

        // Back-to-back table with rsp_ready held high.
        for (int i = 0; i < 6; i++) begin
            if (i == 1) checkGap = 1'b1;
            applyStimulus(table1[i].a, table1[i].b, table1[i].ctrl, table1[i].c, 1'b0, 5);
        end
        waitDrain();
        checkGap = 1'b0;
        checkOutput("opCountTable", int'(opCount), 7);
        checkOutput("aluAHold", int'(bus.alu_a), 6);

        // Reset mid-idle.
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        checkOutput("readyMidReset", int'(bus.req_ready), 0);
        @(posedge clk);
        #2;
        @(negedge clk);
        checkOutput("aluAReset", int'(bus.alu_a), 0);
        checkOutput("aluBReset", int'(bus.alu_b), 0);
        checkOutput("aluCtrlReset", int'(bus.alu_ctrl), 0);
        checkOutput("opCountMidReset", int'(opCount), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterMidReset", int'(bus.req_ready), 1);

        // Response back-pressure with a competing request held.
        bus.rsp_ready = 1'b0;
        applyStimulus(4'd3, 4'd4, 2'd0, 4'd7, 1'b0, 5);
        n = 0;
        while (!bus.rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        bus.req_valid = 1'b1;
        bus.req_a     = 4'd1;
        bus.req_b     = 4'd1;
        acc0          = acceptCount;
        repeat (10) @(negedge clk);
        checkOutput("heldRspValid", int'(bus.rsp_valid), 1);
        checkOutput("heldRspC", int'(bus.rsp_c), 7);
        checkOutput("noReadyInResp", int'(bus.req_ready), 0);
        checkOutput("noSecondAccept", acceptCount - acc0, 0);
        expQ.push_back('{c: 4'd2, unstable: 1'b0, latency: 5});
        @(posedge clk);
        #2 bus.rsp_ready = 1'b1;
        n = 0;
        while (acceptCount == acc0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2 bus.req_valid = 1'b0;
        waitDrain();

        // C never settles: three failed attempts.
        applyStimulus(4'd2, 4'd3, 2'd0, 4'd10, 1'b1, 15);
        toggleLeft = 1000;
        waitDrain();
        @(posedge clk);
        #2;
        toggleLeft = 0;
        cMask      = '0;

        // C settles on the second attempt.
        applyStimulus(4'd4, 4'd4, 2'd0, 4'd7, 1'b0, 10);
        toggleLeft = 5;
        waitDrain();
        @(posedge clk);
        #2 cMask = '0;

        // Reset while settling discards the request.
        applyStimulus(4'd1, 4'd2, 2'd0, 4'd3, 1'b0, 5);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        expQ.delete();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("noRspAfterReset", int'(bus.rsp_valid), 0);
        checkOutput("opCountAfterReset", int'(opCount), 0);

        // op_count wraps after 256 completions.
        for (int i = 0; i < 255; i++) begin
            applyStimulus(4'(i), 4'd1, 2'(i), 4'(i + 1), 1'b0, 5);
        end
        waitDrain();
        checkOutput("opCount255", int'(opCount), 255);
        applyStimulus(4'd8, 4'd8, 2'd0, 4'd0, 1'b0, 5);
        waitDrain();
        checkOutput("opCountWrap", int'(opCount), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
